wb_soc_fabric: RTL

WB_SOC_FABRIC -- requirements
Module: wb_soc_fabric

---
 rtl/wb_soc_fabric.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_soc_fabric.sv
// Two-master Wishbone crossbar-lite: arbitrates m0/m1 one transaction at a
// time onto NUM_SLAVES address-decoded slave ports, with bus timeout and
// unmapped-address error generation.
//   wb_clk/wb_rst         : clock, synchronous active-high reset
//   m0_* / m1_*           : master ports (adr, dat, sel, we, cyc, stb in;
//                           rdt, ack, err out); m1 wins ties only in turn
//   s_*                   : packed slave ports, slave 0 in the LSBs
//   timeout_evt           : one-cycle pulse when a slave fails to respond
//   decode_evt            : one-cycle pulse when no slave matches an address
module wb_soc_fabric #(
  parameter int unsigned                NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE = {32'h4000_1000, 32'h4000_0000,
                                                      32'h0001_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                                      32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned                TIMEOUT    = 255
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [31:0]                m0_adr,
  input  logic [31:0]                m0_dat,
  input  logic [3:0]                 m0_sel,
  input  logic                       m0_we,
  input  logic                       m0_cyc,
  input  logic                       m0_stb,
  output logic [31:0]                m0_rdt,
  output logic                       m0_ack,
  output logic                       m0_err,
  input  logic [31:0]                m1_adr,
  input  logic [31:0]                m1_dat,
  input  logic [3:0]                 m1_sel,
  input  logic                       m1_we,
  input  logic                       m1_cyc,
  input  logic                       m1_stb,
  output logic [31:0]                m1_rdt,
  output logic                       m1_ack,
  output logic                       m1_err,
  output logic [32*NUM_SLAVES-1:0]   s_adr,
  output logic [32*NUM_SLAVES-1:0]   s_dat,
  output logic [4*NUM_SLAVES-1:0]    s_sel,
  output logic [NUM_SLAVES-1:0]      s_we,
  output logic [NUM_SLAVES-1:0]      s_cyc,
  output logic [NUM_SLAVES-1:0]      s_stb,
  input  logic [32*NUM_SLAVES-1:0]   s_rdt,
  input  logic [NUM_SLAVES-1:0]      s_ack,
  input  logic [NUM_SLAVES-1:0]      s_err,
  output logic                       timeout_evt,
  output logic                       decode_evt
);

  localparam int unsigned IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_gnt;      // 0 = m0, 1 = m1
  logic              r_last;     // master granted by the last finished transaction
  logic [IDXW-1:0]   r_sel;
  logic [CNTW-1:0]   r_cnt;
  logic              r_timeout_evt;
  logic              r_decode_evt;

  logic              w_req0;
  logic              w_req1;
  logic              w_pick;
  logic [31:0]       w_pick_adr;
  logic              w_hit;
  logic [IDXW-1:0]   w_idx;
  logic [31:0]       w_srdt [NUM_SLAVES];
  logic [31:0]       w_gadr;
  logic [31:0]       w_gdat;
  logic [3:0]        w_gsel;
  logic              w_gwe;
  logic              w_gcyc;
  logic              w_gstb;
  logic              w_active;
  logic              w_err_st;
  logic              w_sack;
  logic              w_serr;
  logic              w_fwd_ack;
  logic              w_fwd_err;
  logic [31:0]       w_fwd_rdt;

  // Arbitration: a lone requester wins; on a tie the master not served last wins.
  assign w_req0     = m0_cyc & m0_stb;
  assign w_req1     = m1_cyc & m1_stb;
  assign w_pick     = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_pick_adr = w_pick ? m1_adr : m0_adr;

  // Address decode of the master about to be granted; lowest index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!w_hit &&
          ((w_pick_adr & SLAVE_MASK[i*32 +: 32]) ==
           (SLAVE_BASE[i*32 +: 32] & SLAVE_MASK[i*32 +: 32]))) begin
        w_hit = 1'b1;
        w_idx = IDXW'(i);
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_SLAVES); g++) begin : g_rdt
    assign w_srdt[g] = s_rdt[g*32 +: 32];
  end

  // Granted master's request, broadcast to every slave port.
  assign w_gadr = r_gnt ? m1_adr : m0_adr;
  assign w_gdat = r_gnt ? m1_dat : m0_dat;
  assign w_gsel = r_gnt ? m1_sel : m0_sel;
  assign w_gwe  = r_gnt ? m1_we  : m0_we;
  assign w_gcyc = r_gnt ? m1_cyc : m0_cyc;
  assign w_gstb = r_gnt ? m1_stb : m0_stb;

  assign s_adr = {NUM_SLAVES{w_gadr}};
  assign s_dat = {NUM_SLAVES{w_gdat}};
  assign s_sel = {NUM_SLAVES{w_gsel}};
  assign s_we  = {NUM_SLAVES{w_gwe}};

  // Reset gates every handshake output so nothing leaks while wb_rst is high.
  assign w_active = (r_state == ST_ACTIVE) & ~wb_rst;
  assign w_err_st = (r_state == ST_ERR) & ~wb_rst;

  always_comb begin
    s_cyc = '0;
    s_stb = '0;
    if (w_active) begin
      s_cyc[r_sel] = w_gcyc;
      s_stb[r_sel] = w_gstb;
    end
  end

  // Response path back to the granted master; an aborted cycle gets no ack.
  assign w_sack    = s_ack[r_sel];
  assign w_serr    = s_err[r_sel];
  assign w_fwd_ack = w_active & w_gcyc & w_sack;
  assign w_fwd_err = (w_active & w_gcyc & w_serr) | w_err_st;
  assign w_fwd_rdt = w_active ? w_srdt[r_sel] : 32'd0;

  assign m0_ack = ~r_gnt & w_fwd_ack;
  assign m0_err = ~r_gnt & w_fwd_err;
  assign m0_rdt = {32{~r_gnt}} & w_fwd_rdt;
  assign m1_ack =  r_gnt & w_fwd_ack;
  assign m1_err =  r_gnt & w_fwd_err;
  assign m1_rdt = {32{r_gnt}} & w_fwd_rdt;

  assign timeout_evt = r_timeout_evt;
  assign decode_evt  = r_decode_evt;

  // Transaction FSM with timeout counter and event pulses.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state       <= ST_IDLE;
      r_gnt         <= 1'b0;
      r_last        <= 1'b1;
      r_sel         <= '0;
      r_cnt         <= '0;
      r_timeout_evt <= 1'b0;
      r_decode_evt  <= 1'b0;
    end else begin
      r_timeout_evt <= 1'b0;
      r_decode_evt  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt <= w_pick;
            if (w_hit) begin
              r_sel   <= w_idx;
              r_cnt   <= '0;
              r_state <= ST_ACTIVE;
            end else begin
              r_decode_evt <= 1'b1;
              r_state      <= ST_ERR;
            end
          end
        end
        ST_ACTIVE: begin
          if (!w_gcyc) begin
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end else if (w_sack | w_serr) begin
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end else if ((r_cnt + 16'd1) == CNTW'(TIMEOUT)) begin
            r_timeout_evt <= 1'b1;
            r_state       <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_ERR: begin
          r_last  <= r_gnt;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
